fb_port_arbiter: RTL and testbench

//  Shares one single-port framebuffer BRAM between two requesters. The first is the Gigatron pixel writer
//  (6.25 MHz-rate bursts, resynchronised into clk_sys upstream). The second is the video scanout reader,

---
 rtl/fb_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_fb_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port framebuffer BRAM between a buffered
// pixel writer and a latency-critical scanout reader. Reads win by default. A
// wait counter forces a write slot so buffered pixels are never stuck forever.
//
// Handshakes:
//   write side - a pixel transfers on the rising edge where wr_valid & wr_ready.
//                wr_ready depends only on registered FIFO occupancy.
//   read side  - a read is accepted on the rising edge where rd_req & rd_ready.
//                rd_valid follows one cycle later, with rd_data = mem_rdata.
module fb_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        fifo_level,
  output logic [15:0]       starve_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [7:0]       WAIT_MAX  = 8'(MAX_WAIT);

  // Grant encoding for the per-cycle slot decision.
  localparam logic [1:0] GNT_IDLE  = 2'd0;
  localparam logic [1:0] GNT_WRITE = 2'd1;
  localparam logic [1:0] GNT_READ  = 2'd2;
  localparam logic [1:0] GNT_FORCE = 2'd3;

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [7:0]        r_wait_cnt;
  logic [15:0]       r_starve_cnt;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_rd_valid;

  logic [1:0] w_grant;
  logic       w_nonempty;
  logic       w_push;
  logic       w_pop;

  assign w_nonempty = (r_level != '0);
  assign wr_ready   = (r_level != LVL_FULL);
  assign w_push     = wr_valid & wr_ready;
  assign w_pop      = (w_grant == GNT_FORCE) || (w_grant == GNT_WRITE);

  assign fifo_level = 3'(r_level);
  assign starve_cnt = r_starve_cnt;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = mem_rdata;

  // Decide the single grant for this cycle: forced write > read > write > idle.
  always_comb begin
    w_grant = GNT_IDLE;
    if ((r_wait_cnt == WAIT_MAX) && w_nonempty) begin
      w_grant = GNT_FORCE;
    end else if (rd_req) begin
      w_grant = GNT_READ;
    end else if (w_nonempty) begin
      w_grant = GNT_WRITE;
    end
  end

  // Drive the BRAM port from the grant; an idle slot keeps the previous address.
  always_comb begin
    mem_addr  = r_last_addr;
    mem_we    = 1'b0;
    mem_wdata = r_fifo_data[r_rd_ptr];
    rd_ready  = (w_grant != GNT_FORCE);
    case (w_grant)
      GNT_FORCE, GNT_WRITE: begin
        mem_addr = r_fifo_addr[r_rd_ptr];
        mem_we   = 1'b1;
      end
      GNT_READ: begin
        mem_addr = rd_addr;
      end
      default: begin
        mem_addr = r_last_addr;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr;
      r_fifo_data[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Starvation tracking: count unserved cycles of a non-empty FIFO, and forced slots.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (!w_nonempty || w_pop) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if ((w_grant == GNT_FORCE) && (r_starve_cnt != 16'hFFFF)) begin
        r_starve_cnt <= r_starve_cnt + 16'd1;
      end
    end
  end

  // Read-return flag and the held BRAM address for idle slots.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_rd_valid  <= 1'b0;
      r_last_addr <= '0;
    end else begin
      r_rd_valid  <= rd_req & rd_ready;
      r_last_addr <= mem_addr;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed bench for the framebuffer port arbiter with a
// behavioural one-cycle-latency BRAM attached to the memory port.
module tb_fb_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_req;
  logic        rd_ready;
  logic [14:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [2:0]  fifo_level;
  logic [15:0] starve_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fb_port_arbiter #(
    .ADDR_W(15), .DATA_W(8), .FIFO_DEPTH(4), .MAX_WAIT(8)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .fifo_level(fifo_level),
    .starve_cnt(starve_cnt)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25 ...
  always #5 clk_sys = ~clk_sys;

  // Behavioural BRAM: read-first, registered output; preloads 0..15 on its first edge.
  logic [7:0] bram [0:32767];
  logic       preloaded = 1'b0;
  always @(posedge clk_sys) begin
    if (!preloaded) begin
      for (int i = 0; i < 16; i++) bram[i] <= 8'(i) ^ 8'h5A;
      preloaded <= 1'b1;
    end else if (mem_we) begin
      bram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= bram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd_req;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        exp_we;
    logic [14:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic [2:0]  exp_level;
    logic        exp_rd_valid;
  } vec_t;

  vec_t vecs [13];

  task automatic set_vec(input int k, input logic rq, input logic wv, input logic [14:0] wa,
                         input logic [7:0] wd, input logic we, input logic [14:0] ea,
                         input logic [7:0] ed, input logic [2:0] lv, input logic rv);
    vecs[k].rd_req       = rq;
    vecs[k].wr_valid     = wv;
    vecs[k].wr_addr      = wa;
    vecs[k].wr_data      = wd;
    vecs[k].exp_we       = we;
    vecs[k].exp_addr     = ea;
    vecs[k].exp_wdata    = ed;
    vecs[k].exp_level    = lv;
    vecs[k].exp_rd_valid = rv;
  endtask

  initial begin
    int          pix;
    int          fk;
    logic        f;
    logic        prev_f;
    logic        exp_wr_ready;
    logic [2:0]  exp_lvl;
    logic [7:0]  exp_b;

    // Table: writes only, then push/pop at level 2 behind two reads (rd_addr = 5).
    //      k  rq  wv  wa   wd  we  addr wdata lvl rv
    set_vec(0,  0,  1, 100,  1, 0,    0,  0,   0,  0);
    set_vec(1,  0,  1, 101,  2, 1,  100,  1,   1,  0);
    set_vec(2,  0,  1, 102,  3, 1,  101,  2,   1,  0);
    set_vec(3,  0,  1, 103,  4, 1,  102,  3,   1,  0);
    set_vec(4,  0,  0,   0,  0, 1,  103,  4,   1,  0);
    set_vec(5,  0,  0,   0,  0, 0,  103,  0,   0,  0);
    set_vec(6,  1,  1, 200, 10, 0,    5,  0,   0,  0);
    set_vec(7,  1,  1, 201, 11, 0,    5,  0,   1,  1);
    set_vec(8,  0,  1, 202, 12, 1,  200, 10,   2,  1);
    set_vec(9,  0,  1, 203, 13, 1,  201, 11,   2,  0);
    set_vec(10, 0,  0,   0,  0, 1,  202, 12,   2,  0);
    set_vec(11, 0,  0,   0,  0, 1,  203, 13,   1,  0);
    set_vec(12, 0,  0,   0,  0, 0,  203,  0,   0,  0);

    // Reset block
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk_sys);
    #1;
    check("reset_level",    32'(fifo_level), 32'd0);
    check("reset_wr_ready", 32'(wr_ready),   32'd1);
    check("reset_rd_valid", 32'(rd_valid),   32'd0);
    check("reset_mem_we",   32'(mem_we),     32'd0);
    check("reset_starve",   32'(starve_cnt), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;

    // Table-driven cycles
    for (int k = 0; k < 13; k++) begin
      @(negedge clk_sys);
      rd_req   = vecs[k].rd_req;
      rd_addr  = 15'd5;
      wr_valid = vecs[k].wr_valid;
      wr_addr  = vecs[k].wr_addr;
      wr_data  = vecs[k].wr_data;
      #1;
      check($sformatf("vec%0d_we", k),       32'(mem_we),     32'(vecs[k].exp_we));
      check($sformatf("vec%0d_addr", k),     32'(mem_addr),   32'(vecs[k].exp_addr));
      check($sformatf("vec%0d_level", k),    32'(fifo_level), 32'(vecs[k].exp_level));
      check($sformatf("vec%0d_rd_ready", k), 32'(rd_ready),   32'd1);
      check($sformatf("vec%0d_wr_ready", k), 32'(wr_ready),   32'd1);
      check($sformatf("vec%0d_rd_valid", k), 32'(rd_valid),   32'(vecs[k].exp_rd_valid));
      if (vecs[k].exp_we)
        check($sformatf("vec%0d_wdata", k), 32'(mem_wdata), 32'(vecs[k].exp_wdata));
    end
    for (int a = 0; a < 4; a++) begin
      check($sformatf("bram_%0d", 100 + a), 32'(bram[100 + a]), 32'(a + 1));
      check($sformatf("bram_%0d", 200 + a), 32'(bram[200 + a]), 32'(10 + a));
    end

    // Reads only: addresses 0..15 back to back, data = addr ^ 8'h5A
    wr_valid = 1'b0;
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk_sys);
      rd_req  = (i < 16);
      rd_addr = 15'(i);
      #1;
      if (i < 16) begin
        check($sformatf("rd%0d_ready", i), 32'(rd_ready), 32'd1);
        check($sformatf("rd%0d_addr", i),  32'(mem_addr), 32'(i));
      end
      check($sformatf("rd%0d_we", i), 32'(mem_we), 32'd0);
      if (i >= 1 && i <= 16) begin
        exp_b = 8'(i - 1) ^ 8'h5A;
        check($sformatf("rd%0d_valid", i), 32'(rd_valid), 32'd1);
        check($sformatf("rd%0d_data", i),  32'(rd_data),  32'(exp_b));
      end else if (i == 17) begin
        check("rd_valid_drop", 32'(rd_valid), 32'd0);
      end
    end

    // Full FIFO and starvation: reads held, 5 pixels offered; forced writes at c = 9,18,27,36,45
    pix = 0; fk = 0; prev_f = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk_sys);
      rd_req  = 1'b1;
      rd_addr = 15'h20;
      if (pix < 5) begin
        wr_valid = 1'b1;
        wr_addr  = 15'(300 + pix);
        wr_data  = 8'(8'h30 + pix);
      end else begin
        wr_valid = 1'b0;
      end
      #1;
      f = (c == 9) || (c == 18) || (c == 27) || (c == 36) || (c == 45);
      check($sformatf("st%0d_rd_ready", c), 32'(rd_ready), 32'(!f));
      check($sformatf("st%0d_we", c),       32'(mem_we),   32'(f));
      if (c > 0)
        check($sformatf("st%0d_rd_valid", c), 32'(rd_valid), 32'(!prev_f));
      if (f) begin
        check($sformatf("st%0d_addr", c),   32'(mem_addr),   32'(300 + fk));
        check($sformatf("st%0d_wdata", c),  32'(mem_wdata),  32'(8'h30 + fk));
        check($sformatf("st%0d_starve", c), 32'(starve_cnt), 32'(fk));
        fk++;
      end
      if (c <= 10) begin
        exp_wr_ready = !(c >= 4 && c <= 9);
        exp_lvl = (c <= 3) ? 3'(c) : ((c <= 9) ? 3'd4 : 3'd3);
        check($sformatf("st%0d_wr_ready", c), 32'(wr_ready),   32'(exp_wr_ready));
        check($sformatf("st%0d_level", c),    32'(fifo_level), 32'(exp_lvl));
      end
      if (wr_valid && wr_ready) pix++;
      prev_f = f;
    end
    @(negedge clk_sys);
    rd_req = 1'b0;
    #1;
    check("st_end_level",  32'(fifo_level), 32'd0);
    check("st_end_starve", 32'(starve_cnt), 32'd5);
    for (int p = 0; p < 5; p++)
      check($sformatf("st_bram_%0d", 300 + p), 32'(bram[300 + p]), 32'(8'h30 + p));

    // Reset mid-operation: level 3 with a read in flight
    for (int d = 0; d < 3; d++) begin
      @(negedge clk_sys);
      rd_req   = 1'b1;
      rd_addr  = 15'h21;
      wr_valid = 1'b1;
      wr_addr  = 15'(400 + d);
      wr_data  = 8'(8'h40 + d);
    end
    @(negedge clk_sys);
    wr_valid = 1'b0;
    #1;
    check("mid_level_before",    32'(fifo_level), 32'd3);
    check("mid_rd_valid_before", 32'(rd_valid),   32'd1);
    reset = 1'b1;
    #1;
    check("mid_level",    32'(fifo_level), 32'd0);
    check("mid_rd_valid", 32'(rd_valid),   32'd0);
    check("mid_wr_ready", 32'(wr_ready),   32'd1);
    check("mid_mem_we",   32'(mem_we),     32'd0);
    check("mid_starve",   32'(starve_cnt), 32'd0);
    @(negedge clk_sys);
    rd_req = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk_sys);
      #1;
      check($sformatf("post%0d_we", e),    32'(mem_we),     32'd0);
      check($sformatf("post%0d_level", e), 32'(fifo_level), 32'd0);
    end
    @(negedge clk_sys);
    wr_valid = 1'b1; wr_addr = 15'd500; wr_data = 8'h77;
    #1;
    check("new_push_we_same_cycle", 32'(mem_we), 32'd0);
    @(negedge clk_sys);
    wr_valid = 1'b0;
    #1;
    check("new_push_we",    32'(mem_we),    32'd1);
    check("new_push_addr",  32'(mem_addr),  32'd500);
    check("new_push_wdata", 32'(mem_wdata), 32'h77);

    // Report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
